// File: rtl/parking_gate_ctrl.sv
// Entrance/exit gate controller: sensor synchronisers, password FSM with lockout,
// single-cycle entry/exit strobes for the downstream occupancy counter.
module parking_gate_ctrl #(
  parameter logic [1:0]  PASS1          = 2'b01,
  parameter logic [1:0]  PASS2          = 2'b10,
  parameter int unsigned WAIT_CYCLES    = 3,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_entrance,
  input  logic       sensor_exit,
  input  logic [1:0] password_1,
  input  logic [1:0] password_2,
  input  logic       parking_full,
  output logic       entry_pulse,
  output logic       exit_pulse,
  output logic       green_led,
  output logic       red_led,
  output logic [2:0] state_out
);

  localparam int unsigned CNT_MAX = (WAIT_CYCLES > LOCKOUT_CYCLES) ? WAIT_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int unsigned TRY_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_PASS  = 3'd1,
    S_WRONG_PASS = 3'd2,
    S_RIGHT_PASS = 3'd3,
    S_FULL       = 3'd4,
    S_LOCKOUT    = 3'd5
  } state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [TRY_W-1:0]   r_tries, w_tries_nxt;
  logic               r_ent_s1, r_ent_s2, r_ent_d;
  logic               r_ext_s1, r_ext_s2, r_ext_d;
  logic               r_entry_pulse, r_exit_pulse, r_green, r_red;
  logic               w_ent_rise, w_ext_rise, w_pass_ok, w_wait_last, w_lock_last;

  // Two-flop synchronisers plus a delayed copy for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ent_s1 <= 1'b0;
      r_ent_s2 <= 1'b0;
      r_ent_d  <= 1'b0;
      r_ext_s1 <= 1'b0;
      r_ext_s2 <= 1'b0;
      r_ext_d  <= 1'b0;
    end else begin
      r_ent_s1 <= sensor_entrance;
      r_ent_s2 <= r_ent_s1;
      r_ent_d  <= r_ent_s2;
      r_ext_s1 <= sensor_exit;
      r_ext_s2 <= r_ext_s1;
      r_ext_d  <= r_ext_s2;
    end
  end

  assign w_ent_rise  = r_ent_s2 & ~r_ent_d;
  assign w_ext_rise  = r_ext_s2 & ~r_ext_d;
  assign w_pass_ok   = (password_1 == PASS1) && (password_2 == PASS2);
  assign w_wait_last = (r_cnt == CNT_W'(WAIT_CYCLES - 1));
  assign w_lock_last = (r_cnt == CNT_W'(LOCKOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tries <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_tries <= w_tries_nxt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = r_cnt;
    w_tries_nxt = r_tries;
    case (r_state)
      S_IDLE: begin
        if (w_ent_rise) begin
          w_cnt_nxt = '0;
          w_next    = parking_full ? S_FULL : S_WAIT_PASS;
        end
      end
      S_WAIT_PASS: begin
        if (!r_ent_s2) begin
          w_next      = S_IDLE;
          w_tries_nxt = '0;
        end else if (w_wait_last) begin
          // Occupancy re-check wins over the password result
          if (parking_full) begin
            w_next = S_FULL;
          end else if (w_pass_ok) begin
            w_next      = S_RIGHT_PASS;
            w_tries_nxt = '0;
          end else if ((r_tries + TRY_W'(1)) == TRY_W'(MAX_TRIES)) begin
            w_next    = S_LOCKOUT;
            w_cnt_nxt = '0;
          end else begin
            w_next      = S_WRONG_PASS;
            w_tries_nxt = r_tries + TRY_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WRONG_PASS: begin
        if (!r_ent_s2) begin
          w_next      = S_IDLE;
          w_tries_nxt = '0;
        end else begin
          w_next    = S_WAIT_PASS;
          w_cnt_nxt = '0;
        end
      end
      S_RIGHT_PASS, S_FULL: begin
        if (!r_ent_s2) begin
          w_next      = S_IDLE;
          w_tries_nxt = '0;
        end
      end
      S_LOCKOUT: begin
        if (w_lock_last) begin
          w_next      = S_IDLE;
          w_tries_nxt = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next      = S_IDLE;
        w_tries_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // LEDs are registered from the next state so they track the state register exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_entry_pulse <= 1'b0;
      r_exit_pulse  <= 1'b0;
      r_green       <= 1'b0;
      r_red         <= 1'b0;
    end else begin
      r_entry_pulse <= (w_next == S_RIGHT_PASS) && (r_state != S_RIGHT_PASS);
      r_exit_pulse  <= w_ext_rise;
      r_green       <= (w_next == S_RIGHT_PASS);
      r_red         <= (w_next == S_WRONG_PASS) || (w_next == S_FULL) || (w_next == S_LOCKOUT);
    end
  end

  assign entry_pulse = r_entry_pulse;
  assign exit_pulse  = r_exit_pulse;
  assign green_led   = r_green;
  assign red_led     = r_red;
  assign state_out   = r_state;

endmodule
